// File: rtl/rmst_pkg.sv
// Shared definitions for the rmst read-master responder: FSM encoding and beat geometry.
package rmst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_XDW        = 128;
    localparam int BYTES_PER_BEAT = DEF_XDW / 8;

endpackage

// File: rtl/rmst_sync_fifo.sv
// Show-ahead synchronous FIFO: data_out always presents the head word while not empty.
module rmst_sync_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  data_in,
    output logic [W-1:0]  data_out,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   used
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // A pop frees the head slot in the same cycle, so push-while-full is legal alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty    = (used == '0);
    assign full     = (used == (AW+1)'(DEPTH));
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

endmodule

// File: rtl/rmst_burst_reader.sv
// One read job -> pipelined single-beat Avalon-MM reads, buffered in a show-ahead FIFO;
// ctrl_done pulses once the consumer has drained every word.
module rmst_burst_reader
    import rmst_pkg::*;
#(
    parameter int XAW        = 32,
    parameter int XDW        = 128,
    parameter int FIFO_DEPTH = 32,
    parameter int FIFO_AW    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_fixed_location,
    input  logic [XAW-1:0]     ctrl_read_base,
    input  logic [XAW-1:0]     ctrl_read_length,
    input  logic               ctrl_go,
    output logic               ctrl_done,
    input  logic               user_read_buffer,
    output logic [XDW-1:0]     user_buffer_data,
    output logic               user_data_available,
    output logic [XAW-1:0]     mst_address,
    output logic               mst_read,
    output logic [XDW/8-1:0]   mst_byteenable,
    input  logic [XDW-1:0]     mst_readdata,
    input  logic               mst_readdatavalid,
    input  logic               mst_waitrequest
);

    localparam logic [XAW-1:0]     BEAT       = XAW'(XDW / 8);
    localparam logic [FIFO_AW+1:0] CREDIT_MAX = (FIFO_AW+2)'(FIFO_DEPTH - 1);

    state_t             state, state_nxt;
    logic [XAW-1:0]     addr, remaining;
    logic               fixed;
    logic [FIFO_AW:0]   outstanding, fifo_used;
    logic [FIFO_AW+1:0] credit;
    logic               fifo_empty, fifo_full, accept;

    // Words in the FIFO plus words in flight; this never rises while a request is stalled,
    // so a raised mst_read cannot drop before it is accepted.
    assign credit   = {1'b0, fifo_used} + {1'b0, outstanding};
    assign mst_read = (state == ST_READ) && (remaining != '0) && (credit < CREDIT_MAX);
    assign accept   = mst_read && !mst_waitrequest;

    assign mst_address         = addr;
    assign mst_byteenable      = '1;
    assign ctrl_done           = (state == ST_DONE);
    assign user_data_available = !fifo_empty;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (ctrl_go)
                          state_nxt = (ctrl_read_length == '0) ? ST_DRAIN : ST_READ;
            ST_READ:  if (remaining == '0 || (accept && remaining <= BEAT))
                          state_nxt = ST_DRAIN;
            ST_DRAIN: if (outstanding == '0 && fifo_empty)
                          state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            addr        <= '0;
            remaining   <= '0;
            fixed       <= 1'b0;
            outstanding <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && ctrl_go) begin
                addr      <= ctrl_read_base;
                remaining <= ctrl_read_length;
                fixed     <= ctrl_fixed_location;
            end else if (accept) begin
                remaining <= remaining - BEAT;
                if (!fixed)
                    addr <= addr + BEAT;
            end
            case ({accept, mst_readdatavalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    rmst_sync_fifo #(
        .W     (XDW),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mst_readdatavalid),
        .pop      (user_read_buffer),
        .data_in  (mst_readdata),
        .data_out (user_buffer_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .used     (fifo_used)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(mst_readdatavalid && fifo_full && !user_read_buffer));

endmodule
